// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_pkg
// Description : Shared op encodings, accumulator states and the bitwise op.
// Revision    : 1.0
// ============================================================================
package logic_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    // Single-bit form so any operand width can apply it bit by bit.
    function automatic logic logic_op(input logic a, input logic b, input logic [1:0] op);
        logic y;
        y = 1'b0;
        case (op)
            OP_XOR:  y = a ^ b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = ~(a ^ b);
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : logic_pipe_stage
// Description : One valid+data register of the result pipeline, with enable.
// Revision    : 1.0
// ============================================================================
module logic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (Reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_pipe_mixed.sv
`default_nettype none
// ============================================================================
// Module      : logic_pipe_mixed
// Description : Bitwise logic unit with combinational result, DEPTH-stage
//               valid/ready pipeline and burst XOR checksum accumulator.
// Revision    : 1.0
// ============================================================================
module logic_pipe_mixed
    import logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             acc_en,
    output logic [WIDTH-1:0] comb_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             acc_valid,
    output logic [WIDTH-1:0] acc_data,
    output logic [CNT_W-1:0] acc_beats
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]            result;
    logic                        adv;
    logic                        accept;
    logic [DEPTH-1:0]            stage_valid;
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;

    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = logic_op(A[i], B[i], op);
        end
    end

    assign comb_out = result;

    // Whole chain moves in lockstep; a stalled output freezes every stage.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk     (clk),
                    .Reset   (Reset),
                    .en      (adv),
                    .d_valid (accept),
                    .d_data  (result),
                    .q_valid (stage_valid[gi]),
                    .q_data  (stage_data[gi])
                );
            end else begin : g_rest
                logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk     (clk),
                    .Reset   (Reset),
                    .en      (adv),
                    .d_valid (stage_valid[gi-1]),
                    .d_data  (stage_data[gi-1]),
                    .q_valid (stage_valid[gi]),
                    .q_data  (stage_data[gi])
                );
            end
        end
    endgenerate

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    acc_state_t       state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             pub_nx;
    logic [WIDTH-1:0] pub_data_nx;
    logic [CNT_W-1:0] pub_beats_nx;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        pub_nx       = 1'b0;
        pub_data_nx  = acc_data;
        pub_beats_nx = acc_beats;
        if (accept && acc_en) begin
            case (state)
                ACC_IDLE: begin
                    if (in_last) begin
                        pub_nx       = 1'b1;
                        pub_data_nx  = result;
                        pub_beats_nx = CNT_ONE;
                    end else begin
                        state_nx = ACC_RUN;
                        acc_nx   = result;
                        cnt_nx   = CNT_ONE;
                    end
                end
                ACC_RUN: begin
                    acc_nx = acc ^ result;
                    cnt_nx = cnt_inc;
                    if (in_last) begin
                        pub_nx       = 1'b1;
                        pub_data_nx  = acc ^ result;
                        pub_beats_nx = cnt_inc;
                        state_nx     = ACC_IDLE;
                    end
                end
                default: state_nx = ACC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= ACC_IDLE;
            acc       <= '0;
            cnt       <= '0;
            acc_valid <= 1'b0;
            acc_data  <= '0;
            acc_beats <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            acc_valid <= pub_nx;
            acc_data  <= pub_data_nx;
            acc_beats <= pub_beats_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_pipe_mixed.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_pipe_mixed
// Description : Self-checking bench with a queue/arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_logic_pipe_mixed;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] A, B;
    logic [1:0] op;
    logic       in_valid, in_last, acc_en, out_ready;
    logic       in_ready, out_valid, acc_valid;
    logic [7:0] comb_out, out_data, acc_data, acc_beats;
    logic       in_ready_s, out_valid_s, acc_valid_s;
    logic [7:0] comb_out_s, out_data_s, acc_data_s;
    logic [1:0] acc_beats_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic_pipe_mixed #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .Reset(Reset), .A(A), .B(B), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .acc_en(acc_en),
        .comb_out(comb_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .acc_valid(acc_valid), .acc_data(acc_data), .acc_beats(acc_beats)
    );

    logic_pipe_mixed #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) dut_s (
        .clk(clk), .Reset(Reset), .A(A), .B(B), .op(op),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last), .acc_en(acc_en),
        .comb_out(comb_out_s), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .acc_valid(acc_valid_s), .acc_data(acc_data_s), .acc_beats(acc_beats_s)
    );

    function automatic logic [7:0] f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        case (o)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Reference model: expected output queue plus burst bookkeeping.
    logic [7:0] exp_q[$];
    logic [7:0] e, r;
    bit         sb_on = 0;
    bit         m_run = 0, m_pub = 0;
    logic [7:0] m_acc = 0, m_data = 0, m_beats = 0;
    logic [1:0] m_beats_s = 0;
    int         m_cnt = 0;

    always @(negedge clk) begin
        if (sb_on) begin
            n_cmp++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b, expected %b", in_ready, out_ready | ~out_valid);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_order: got out_data %h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_order: got out_data %h, expected %h", out_data, e);
                    end
                end
            end
            n_cmp++;
            if (acc_valid !== m_pub || acc_data !== m_data || acc_beats !== m_beats
                || acc_beats_s !== m_beats_s || acc_valid_s !== m_pub) begin
                n_fail++;
                $display("FAIL sb_acc: got v=%b d=%h n=%0d ns=%0d, expected v=%b d=%h n=%0d ns=%0d",
                         acc_valid, acc_data, acc_beats, acc_beats_s, m_pub, m_data, m_beats, m_beats_s);
            end
        end
        if (Reset) begin
            exp_q.delete();
            m_run = 0; m_pub = 0; m_data = 0; m_beats = 0; m_beats_s = 0; m_acc = 0; m_cnt = 0;
            sb_on = 1;
        end else begin
            m_pub = 0;
            if (in_valid && in_ready) begin
                r = f(A, B, op);
                exp_q.push_back(r);
                if (acc_en) begin
                    if (!m_run) begin
                        m_acc = r;
                        m_cnt = 1;
                    end else begin
                        m_acc = m_acc ^ r;
                        m_cnt = m_cnt + 1;
                    end
                    m_run = 1;
                    if (in_last) begin
                        m_pub     = 1;
                        m_data    = m_acc;
                        m_beats   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
                        m_beats_s = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
                        m_run     = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                        input logic en, input logic last);
        int k;
        A = a; B = b; op = o; acc_en = en; in_last = last; in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got %b, expected 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1; in_valid = 1; A = 8'hFF; B = 8'h0F; op = 2'd0;
        acc_en = 1; in_last = 1; out_ready = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || acc_valid !== 1'b0 || acc_beats !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state: got ov=%b od=%h av=%b ab=%h, expected 0/00/0/00",
                         out_valid, out_data, acc_valid, acc_beats);
            end
            n_cmp++;
            if (comb_out !== 8'hF0) begin
                n_fail++;
                $display("FAIL reset_comb: got %h, expected f0", comb_out);
            end
            @(posedge clk); #1;
        end
        Reset = 0; in_valid = 0; in_last = 0; acc_en = 0;
        idle(1);
    endtask

    task automatic test_per_op();
        logic [7:0] want [4];
        want[0] = 8'h99; want[1] = 8'h24; want[2] = 8'hBD; want[3] = 8'h66;
        out_ready = 1;
        for (int o = 0; o < 4; o++) begin
            A = 8'hA5; B = 8'h3C; op = 2'(o); acc_en = 0; in_last = 0; in_valid = 1;
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1 || comb_out !== want[o]) begin
                n_fail++;
                $display("FAIL op%0d_accept: got rdy=%b comb=%h, expected 1/%h", o, in_ready, comb_out, want[o]);
            end
            @(posedge clk); #1;
            in_valid = 0;
            op = 2'(o + 1);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_early: out_valid got %b, expected 0", o, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== want[o]) begin
                n_fail++;
                $display("FAIL op%0d_latency: got v=%b d=%h, expected 1/%h", o, out_valid, out_data, want[o]);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_pulse: out_valid got %b, expected 0", o, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        out_ready = 1;
        send(8'd1, 8'd0, 2'd0, 1'b0, 1'b0);
        send(8'd2, 8'd0, 2'd0, 1'b0, 1'b0);
        out_ready = 0;
        A = 8'd3; B = 8'd0; op = 2'd0; acc_en = 0; in_last = 0; in_valid = 1;
        held = 8'hxx;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) held = out_data;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd1 || out_data !== held) begin
                n_fail++;
                $display("FAIL stall_hold: got rdy=%b v=%b d=%h, expected 0/1/01", in_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(8'd3, 8'd0, 2'd0, 1'b0, 1'b0);
        send(8'd4, 8'd0, 2'd0, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: %0d beats outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        out_ready = 1;
        send(8'h01, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h02, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h04, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h80, 8'h00, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_data !== 8'h87 || acc_beats !== 8'd4 || acc_beats_s !== 2'd3) begin
            n_fail++;
            $display("FAIL burst4: got v=%b d=%h n=%0d ns=%0d, expected 1/87/4/3",
                     acc_valid, acc_data, acc_beats, acc_beats_s);
        end
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b0 || acc_data !== 8'h87) begin
            n_fail++;
            $display("FAIL burst4_hold: got v=%b d=%h, expected 0/87", acc_valid, acc_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_and_gap();
        out_ready = 1;
        send(8'h5A, 8'h00, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_data !== 8'h5A || acc_beats !== 8'd1) begin
            n_fail++;
            $display("FAIL single: got v=%b d=%h n=%0d, expected 1/5a/1", acc_valid, acc_data, acc_beats);
        end
        @(posedge clk); #1;
        send(8'h11, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h22, 8'h00, 2'd0, 1'b0, 1'b1);
        send(8'h44, 8'h00, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_data !== 8'h55 || acc_beats !== 8'd2) begin
            n_fail++;
            $display("FAIL gap: got v=%b d=%h n=%0d, expected 1/55/2", acc_valid, acc_data, acc_beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_and_sat();
        out_ready = 1;
        send(8'h01, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h02, 8'h00, 2'd0, 1'b1, 1'b0);
        Reset = 1;
        @(posedge clk); #1;
        Reset = 0;
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b0 || acc_data !== 8'h00 || acc_beats !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%h n=%0d, expected 0/00/0", acc_valid, acc_data, acc_beats);
        end
        @(posedge clk); #1;
        send(8'h03, 8'h00, 2'd0, 1'b1, 1'b0);
        send(8'h30, 8'h00, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_data !== 8'h33 || acc_beats !== 8'd2) begin
            n_fail++;
            $display("FAIL fresh_burst: got v=%b d=%h n=%0d, expected 1/33/2", acc_valid, acc_data, acc_beats);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send(8'(1 << i), 8'h00, 2'd0, 1'b1, (i == 4) ? 1'b1 : 1'b0);
        @(negedge clk);
        n_cmp++;
        if (acc_valid_s !== 1'b1 || acc_data_s !== 8'h1F || acc_beats_s !== 2'd3 || acc_beats !== 8'd5) begin
            n_fail++;
            $display("FAIL saturate: got v=%b d=%h ns=%0d n=%0d, expected 1/1f/3/5",
                     acc_valid_s, acc_data_s, acc_beats_s, acc_beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            Reset     = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 8'($urandom);
            B         = 8'($urandom);
            op        = 2'($urandom);
            acc_en    = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_cmp++;
            if (comb_out !== f(A, B, op)) begin
                n_fail++;
                $display("FAIL rand_comb: got %h, expected %h", comb_out, f(A, B, op));
            end
            @(posedge clk); #1;
        end
        Reset = 0; in_valid = 0; in_last = 0; out_ready = 1;
        idle(5);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: %0d beats outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_per_op();
        test_backpressure();
        test_burst();
        test_single_and_gap();
        test_reset_mid_and_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
